dma_master_burst: RTL and testbench
===================================

Name: dma_master_burst

Overview:
- Parametrised successor to the single-channel DMA master: copies qty words from a source to a destination over an AXI master port using INCR bursts.
- The read and write engines are decoupled through an internal FIFO, so reads of burst n+1 overlap writes of burst n.
- Bursts are split at MAX_BURST beats and at BOUNDARY-byte address boundaries.
- Sits between the CPU-programmed DMA register block (start/addr/qty) and the AXI bus; interrupt comes from done_o.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; one beat = one word = DATA_W/8 bytes.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant ARID/AWID value.
- MAX_BURST, 16, maximum beats per burst (1..256).
- FIFO_DEPTH, 16, FIFO entries; power of 2 and >= MAX_BURST.
- BOUNDARY, 1024, byte boundary no burst may cross; power of 2 and >= MAX_BURST*DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle start pulse; sampled only when busy_o=0
- src_addr_i / dst_addr_i  in  ADDR_W  byte addresses; low log2(DATA_W/8) bits forced to 0
- qty_i  in  32  number of words to copy
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error: any RRESP/BRESP != OKAY in the current transfer; cleared on accepted start
- m_arvalid/m_arready  out/in  1  AR handshake
- m_araddr  out  ADDR_W; m_arlen  out  8; m_arsize  out  3 (=log2(DATA_W/8)); m_arburst  out  2 (=INCR); m_arid  out  ID_W
- m_rvalid/m_rready  in/out  1; m_rdata  in  DATA_W; m_rresp  in  2; m_rlast  in  1
- m_awvalid/m_awready  out/in  1; m_awaddr  out  ADDR_W; m_awlen  out  8; m_awsize  out  3; m_awburst  out  2; m_awid  out  ID_W
- m_wvalid/m_wready  out/in  1; m_wdata  out  DATA_W; m_wstrb  out  DATA_W/8 (all ones); m_wlast  out  1
- m_bvalid/m_bready  in/out  1; m_bresp  in  2

Behaviour:
- Reset: all outputs 0. Both FSMs go IDLE, FIFO is emptied, counters are cleared. Reset mid-transfer drops every valid/ready immediately; no completion pulse is generated.
- Accepted start (start_i & ~busy_o):
  - Latches addresses and qty; rd_rem = wr_rem = qty_i; clears err_o.
  - busy_o=1 from the next cycle.
  - qty_i=0: busy_o stays 0, done_o pulses the next cycle, no AXI traffic.
- Burst length calculation (per engine, from its own address and remaining count): len = min(MAX_BURST, rem, (BOUNDARY - addr%BOUNDARY)/(DATA_W/8)). AxLEN = len-1.
- Read FSM (R_IDLE -> R_AR -> R_DATA):
  - R_IDLE -> R_AR when rd_rem>0 and FIFO free entries >= rd_len. No R backpressure is ever needed; rready=1 in R_DATA.
  - arvalid held with stable fields until arready.
  - Each R beat pushes rdata into the FIFO.
  - On rlast: rd_addr += len*DATA_W/8, rd_rem -= len, return to R_IDLE.
- Write FSM (W_IDLE -> W_AW -> W_DATA -> W_B):
  - W_IDLE -> W_AW when wr_rem>0 and FIFO count >= wr_len.
  - W_DATA: wvalid=1 while FIFO is non-empty; wdata = FIFO head; pop on wvalid&wready.
  - wlast=1 on beat len-1, counted by an internal beat counter; never driven by rlast.
  - W_B: bready=1. On B handshake: update wr_addr and wr_rem.
  - If wr_rem becomes 0, pulse done_o; busy_o drops in the same cycle.
- Read and write lengths may differ per burst (different alignment); the FIFO absorbs the mismatch.
- Simultaneous FIFO push and pop in the same cycle is legal; count is unchanged.
- Error responses: err_o is set and the transfer still completes.
- An early rlast, or a missing rlast, is a protocol violation; behaviour is undefined and is flagged by the assertion.
- Address arithmetic wraps modulo 2^ADDR_W.
- start_i while busy is ignored.

Optional Feature:
- DMA_PERF_CNT_EN defined: adds output perf_cycles_o [31:0].
  - Counts cycles while busy_o=1, saturating at 32'hFFFFFFFF.
  - Cleared on accepted start; holds its value after done_o.
- Not defined: the port and the counter are absent.

Test Plan:
- Unaligned split: src=0x1000_0000, dst=0x2000_03F8, qty=20, MAX_BURST=16, BOUNDARY=1024 -> AR lens 15,3 (16,4 beats); AW lens 1,15,1 (2,16,2 beats); destination holds the source words in order; one done_o pulse.
- Zero quantity: qty=0 -> done_o one cycle after start; no AR/AW valid seen.
- Backpressure: wready toggled 50% random, qty=64 -> rvalid never stalls (rready=1 whenever the slave offers R data), FIFO never overflows, data matches.
- Error response: bresp=SLVERR on the 2nd burst of a qty=48 transfer -> err_o=1 sticky, all 48 words written, done_o pulses; the next start clears err_o.
- Reset mid-transfer: rst asserted during W_DATA -> all valids are 0 the same cycle, busy_o=0, no done_o pulse; a new start afterwards completes correctly.
- DMA_PERF_CNT_EN: qty=16 with zero-wait slave -> perf_cycles_o equals the busy_o high cycle count and holds after done_o.

Source files
------------

// File: rtl/dma_master_burst.sv
`default_nettype none
// ============================================================================
// Module   : dma_master_burst
// Purpose  : Burst DMA copy engine: read FSM -> FIFO -> write FSM on one AXI
//            master port. Define DMA_PERF_CNT_EN to add perf_cycles_o.
// Revision : 1.0
// ============================================================================
module dma_master_burst #(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              ID_W       = 4,
    parameter logic [ID_W-1:0] AXI_ID     = '0,
    parameter int              MAX_BURST  = 16,
    parameter int              FIFO_DEPTH = 16,
    parameter int              BOUNDARY   = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   src_addr_i,
    input  logic [ADDR_W-1:0]   dst_addr_i,
    input  logic [31:0]         qty_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic [ID_W-1:0]     m_arid,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic [ID_W-1:0]     m_awid,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp
`ifdef DMA_PERF_CNT_EN
    ,
    output logic [31:0]         perf_cycles_o
`endif
);

    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int BW    = $clog2(BOUNDARY);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = PW + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wr_state_t;

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;

    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [31:0]       rd_rem, wr_rem;
    logic [8:0]        rd_len, wr_len, ar_len, aw_len, rd_beat, wr_beat;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic              start_ok, r_fire, w_fire, b_fire, b_last, rd_starved, wr_last_beat;

    // Beats allowed from addr: limited by MAX_BURST, remaining words and the boundary.
    function automatic logic [8:0] burst_len(input logic [ADDR_W-1:0] addr, input logic [31:0] rem);
        logic [31:0] room, len;
        room = (32'(BOUNDARY) - 32'(addr[BW-1:0])) >> SZ;
        len  = 32'(MAX_BURST);
        if (rem < len)  len = rem;
        if (room < len) len = room;
        return len[8:0];
    endfunction

    assign rd_len       = burst_len(rd_addr, rd_rem);
    assign wr_len       = burst_len(wr_addr, wr_rem);
    assign start_ok     = start_i & ~busy_o;
    assign r_fire       = m_rvalid & m_rready;
    assign w_fire       = m_wvalid & m_wready;
    assign b_fire       = m_bvalid & m_bready;
    assign b_last       = b_fire && (wr_rem == 32'(aw_len));
    assign wr_last_beat = (wr_beat == aw_len - 9'd1);
    // A short first write can leave the FIFO too full to read yet too empty to
    // write a full burst; let the writer start and drain it in that case.
    assign rd_starved   = (rd_state == R_IDLE) && (rd_rem != 0) &&
                          ((32'(FIFO_DEPTH) - 32'(count)) < 32'(rd_len));

    assign m_araddr  = rd_addr;
    assign m_arlen   = 8'(ar_len - 9'd1);
    assign m_arsize  = 3'(SZ);
    assign m_arburst = 2'b01;
    assign m_arid    = AXI_ID;
    assign m_awaddr  = wr_addr;
    assign m_awlen   = 8'(aw_len - 9'd1);
    assign m_awsize  = 3'(SZ);
    assign m_awburst = 2'b01;
    assign m_awid    = AXI_ID;
    assign m_wdata   = fifo_mem[rptr];
    assign m_wstrb   = '1;

    always_comb begin
        rd_next   = rd_state;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        unique case (rd_state)
            R_IDLE:  if (rd_rem != 0 && (32'(FIFO_DEPTH) - 32'(count)) >= 32'(rd_len)) rd_next = R_AR;
            R_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) rd_next = R_DATA;
            end
            R_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid && m_rlast) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        wr_next   = wr_state;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        unique case (wr_state)
            W_IDLE:  if (wr_rem != 0 && (32'(count) >= 32'(wr_len) || rd_starved)) wr_next = W_AW;
            W_AW: begin
                m_awvalid = 1'b1;
                if (m_awready) wr_next = W_DATA;
            end
            W_DATA: begin
                m_wvalid = (count != 0);
                m_wlast  = wr_last_beat;
                if (count != 0 && m_wready && wr_last_beat) wr_next = W_B;
            end
            W_B: begin
                m_bready = 1'b1;
                if (m_bvalid) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
            rd_addr  <= '0;
            wr_addr  <= '0;
            rd_rem   <= '0;
            wr_rem   <= '0;
            ar_len   <= '0;
            aw_len   <= '0;
            rd_beat  <= '0;
            wr_beat  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
            done_o   <= 1'b0;
            if (start_ok) begin
                rd_addr <= src_addr_i & ALIGN_MASK;
                wr_addr <= dst_addr_i & ALIGN_MASK;
                rd_rem  <= qty_i;
                wr_rem  <= qty_i;
                err_o   <= 1'b0;
                busy_o  <= (qty_i != 0);
                done_o  <= (qty_i == 0);
            end else begin
                if ((r_fire && m_rresp != 2'b00) || (b_fire && m_bresp != 2'b00)) err_o <= 1'b1;
                if (b_last) begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
            end
            if (rd_state == R_IDLE && rd_next == R_AR) ar_len <= rd_len;
            if (wr_state == W_IDLE && wr_next == W_AW) aw_len <= wr_len;
            if (r_fire) begin
                rd_beat <= m_rlast ? 9'd0 : rd_beat + 9'd1;
                wptr    <= wptr + 1'b1;
                if (m_rlast) begin
                    rd_addr <= rd_addr + (ADDR_W'(ar_len) << SZ);
                    rd_rem  <= rd_rem - 32'(ar_len);
                end
            end
            if (w_fire) begin
                wr_beat <= m_wlast ? 9'd0 : wr_beat + 9'd1;
                rptr    <= rptr + 1'b1;
            end
            if (b_fire) begin
                wr_addr <= wr_addr + (ADDR_W'(aw_len) << SZ);
                wr_rem  <= wr_rem - 32'(aw_len);
            end
            if (r_fire && !w_fire)      count <= count + 1'b1;
            else if (!r_fire && w_fire) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_fire) fifo_mem[wptr] <= m_rdata;
    end

`ifdef DMA_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           perf_cycles_o <= '0;
        else if (start_ok)                                 perf_cycles_o <= '0;
        else if (busy_o && perf_cycles_o != 32'hFFFF_FFFF) perf_cycles_o <= perf_cycles_o + 32'd1;
    end
`endif

    // The slave must end each read burst exactly on the requested beat count.
    a_rlast_position: assert property (@(posedge clk) disable iff (rst)
        (m_rvalid && m_rready) |-> (m_rlast == (rd_beat == ar_len - 9'd1)));

endmodule
`default_nettype wire

// File: tb/tb_dma_master_burst.sv
`default_nettype none
// tb_dma_master_burst: directed sequence against a behavioural AXI slave;
// expected writes and burst lengths are queued at start and checked as beats arrive.
module tb_dma_master_burst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0, dst_addr_i = '0, qty_i = '0;
    logic        busy_o, done_o, err_o;
    logic        m_arvalid, m_arready = 1'b0;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [3:0]  m_arid;
    logic        m_rvalid = 1'b0, m_rready, m_rlast = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = 2'b00;
    logic        m_awvalid, m_awready = 1'b0;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic [3:0]  m_awid;
    logic        m_wvalid, m_wready = 1'b0, m_wlast;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid = 1'b0, m_bready;
    logic [1:0]  m_bresp = 2'b00;
`ifdef DMA_PERF_CNT_EN
    logic [31:0] perf_cycles_o;
`endif

    dma_master_burst #(.MAX_BURST(16), .FIFO_DEPTH(16), .BOUNDARY(1024)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .src_addr_i(src_addr_i),
        .dst_addr_i(dst_addr_i), .qty_i(qty_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
`ifdef DMA_PERF_CNT_EN
        , .perf_cycles_o(perf_cycles_o)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {logic [31:0] addr; logic [8:0] len;} burst_t;
    typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;

    burst_t rd_q[$], aw_q[$];
    wr_t    sb[$];
    int     exp_ar[$], exp_aw[$];
    int     checks = 0, errors = 0;
    int     rd_beat = 0, wr_beat = 0, b_pend = 0, b_idx = 0, err_b_idx = -1;
    int     done_cnt = 0, axi_seen = 0, busy_cnt = 0;
    bit     chk_len = 1'b0, bp_mode = 1'b0;

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave drives at the negedge for the next posedge and books the handshake now.
    task automatic slave_step();
        wr_t    e;
        logic [31:0] a;
        if (rst) begin
            rd_q.delete(); aw_q.delete(); sb.delete(); exp_ar.delete(); exp_aw.delete();
            rd_beat = 0; wr_beat = 0; b_pend = 0;
            m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_rlast = 0; m_bvalid = 0;
        end else begin
            if (done_o) done_cnt++;
            if (busy_o) busy_cnt++;
            if (m_arvalid || m_awvalid) axi_seen++;
            m_arready = 1'b1;
            m_awready = 1'b1;
            m_wready  = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_q.size() > 0) begin
                m_rvalid = 1'b1;
                m_rdata  = src_word(rd_q[0].addr + 32'(rd_beat * 4));
                m_rlast  = (rd_beat == int'(rd_q[0].len) - 1);
            end else begin
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
            end
            m_bvalid = (b_pend > 0);
            m_bresp  = (b_idx == err_b_idx) ? 2'b10 : 2'b00;

            if (m_arvalid) begin
                rd_q.push_back({m_araddr, 9'(m_arlen) + 9'd1});
                chk("arsize_arburst_arid", {m_arsize, m_arburst, m_arid}, {3'd2, 2'b01, 4'd0});
                if (chk_len && exp_ar.size() > 0) chk("arlen", m_arlen, 64'(exp_ar.pop_front()));
            end
            if (m_rvalid) begin
                chk("rready_when_rvalid", m_rready, 1'b1);
                if (m_rready) begin
                    rd_beat++;
                    if (m_rlast) begin void'(rd_q.pop_front()); rd_beat = 0; end
                end
            end
            if (m_awvalid) begin
                aw_q.push_back({m_awaddr, 9'(m_awlen) + 9'd1});
                chk("awsize_awburst_awid", {m_awsize, m_awburst, m_awid}, {3'd2, 2'b01, 4'd0});
                if (chk_len && exp_aw.size() > 0) chk("awlen", m_awlen, 64'(exp_aw.pop_front()));
            end
            if (m_wvalid && m_wready) begin
                chk("w_after_aw", 64'(aw_q.size() != 0), 64'd1);
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (aw_q.size() != 0 && sb.size() != 0) begin
                    a = aw_q[0].addr + 32'(wr_beat * 4);
                    e = sb.pop_front();
                    chk("w_addr", a, e.addr);
                    chk("w_data", m_wdata, e.data);
                    chk("w_strb", m_wstrb, 4'hF);
                    chk("w_last", m_wlast, 64'(wr_beat == int'(aw_q[0].len) - 1));
                    wr_beat++;
                    if (m_wlast) begin void'(aw_q.pop_front()); wr_beat = 0; b_pend++; end
                end
            end
            if (m_bvalid && m_bready) begin
                b_pend--;
                b_idx++;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        slave_step();
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input int qty);
        for (int i = 0; i < qty; i++) sb.push_back({dst + 32'(i * 4), src_word(src + 32'(i * 4))});
        src_addr_i = src; dst_addr_i = dst; qty_i = 32'(qty); start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (done_o !== 1'b1 && n < bound) begin step(); n++; end
        chk({tag, "_done_in_time"}, done_o, 1'b1);
        chk({tag, "_busy_low_at_done"}, busy_o, 1'b0);
        step();
        chk({tag, "_done_one_cycle"}, done_o, 1'b0);
        chk({tag, "_all_words_written"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, bc0;
        logic [31:0] perf_snap;
        repeat (3) step();
        chk("reset_status", {busy_o, done_o, err_o}, 3'b000);
        chk("reset_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, m_wlast}, 6'b0);
`ifdef DMA_PERF_CNT_EN
        chk("reset_perf", perf_cycles_o, 32'd0);
`endif
        rst = 1'b0;
        step();

        // Unaligned destination split across a 1 KiB boundary
        chk_len = 1'b1;
        exp_ar = '{15, 3};
        exp_aw = '{1, 15, 1};
        dc = done_cnt;
        start_xfer(32'h1000_0000, 32'h2000_03F8, 20);
        chk("t1_busy_after_start", busy_o, 1'b1);
        wait_done("t1", 1000);
        chk("t1_ar_lens_consumed", 64'(exp_ar.size()), 64'd0);
        chk("t1_aw_lens_consumed", 64'(exp_aw.size()), 64'd0);
        chk("t1_one_done_pulse", 64'(done_cnt - dc), 64'd1);
        chk("t1_no_error", err_o, 1'b0);
        chk_len = 1'b0;

        // Zero quantity
        dc = axi_seen;
        start_xfer(32'h1100_0000, 32'h2100_0000, 0);
        chk("t2_done_next_cycle", done_o, 1'b1);
        chk("t2_busy_stays_low", busy_o, 1'b0);
        step();
        chk("t2_done_single", done_o, 1'b0);
        repeat (4) step();
        chk("t2_no_axi_traffic", 64'(axi_seen - dc), 64'd0);

        // Write backpressure; a start pulse while busy must be ignored
        bp_mode = 1'b1;
        start_xfer(32'h3000_0100, 32'h4000_0000, 64);
        repeat (5) step();
        src_addr_i = 32'h3300_0000; dst_addr_i = 32'h4400_0000; qty_i = 32'd5; start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_done("t3", 3000);
        bp_mode = 1'b0;

        // SLVERR on the second write burst
        err_b_idx = b_idx + 1;
        start_xfer(32'h5000_0000, 32'h6000_0000, 48);
        wait_done("t4", 1500);
        chk("t4_err_sticky", err_o, 1'b1);
        err_b_idx = -1;
        start_xfer(32'h5000_1000, 32'h6000_1000, 4);
        chk("t4_err_cleared_by_start", err_o, 1'b0);
        wait_done("t4b", 500);
        chk("t4b_no_error", err_o, 1'b0);

        // Reset while the write engine is streaming data
        start_xfer(32'h7000_0000, 32'h7100_0000, 32);
        begin
            int n = 0;
            while (m_wvalid !== 1'b1 && n < 500) begin step(); n++; end
        end
        chk("t5_reached_wdata", m_wvalid, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        dc = done_cnt;
        chk("t5_valids_drop_in_reset", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 5'b0);
        chk("t5_status_in_reset", {busy_o, done_o}, 2'b00);
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        chk("t5_no_done_after_reset", 64'(done_cnt - dc), 64'd0);
        start_xfer(32'h7200_0000, 32'h7300_0010, 8);
        wait_done("t5b", 500);

`ifdef DMA_PERF_CNT_EN
        bc0 = busy_cnt;
        start_xfer(32'h8000_0000, 32'h8100_0000, 16);
        wait_done("t6", 500);
        perf_snap = perf_cycles_o;
        chk("t6_perf_equals_busy_cycles", perf_snap, 32'(busy_cnt - bc0));
        repeat (3) step();
        chk("t6_perf_holds", perf_cycles_o, 32'(busy_cnt - bc0));
`else
        bc0 = 0;
        perf_snap = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
